// File: rtl/bb_dffrs_pipe.sv
// bb_dffrs_pipe: DEPTH-stage valid/ready register pipeline with bubble collapsing.
// An item advances whenever any stage ahead of it is empty or the output is taken.
// Controls: async active-low reset (data -> RST_VAL), sync active-low set
// (data -> SET_VAL, pipe flushed), and sync clear (pipe flushed, data kept).
module bb_dffrs_pipe #(
  parameter int unsigned    DW      = 2,
  parameter int unsigned    DEPTH   = 4,
  parameter logic [DW-1:0]  RST_VAL = '0,
  parameter logic [DW-1:0]  SET_VAL = DW'(1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         set_n,
  input  logic                         clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DW-1:0]                in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DW-1:0]                out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] load_en;
  logic [CW-1:0]    count_d;

  // Ready chain: a stage may load if it is empty or the stage after it may load.
  always_comb begin : ready_chain
    logic en;
    load_en = '0;
    en      = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      en         = ~valid_q[i] | en;
      load_en[i] = en;
    end
  end

  // Next-state for every stage; data only moves with a valid item so an empty
  // stage keeps whatever it last held.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (!set_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = SET_VAL;
      end
      valid_d = '0;
    end else if (clr) begin
      valid_d = '0;
    end else begin
      if (load_en[0]) begin
        valid_d[0] = in_valid;
        if (in_valid) begin
          data_d[0] = in_data;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (load_en[i]) begin
          valid_d[i] = valid_q[i-1];
          if (valid_q[i-1]) begin
            data_d[i] = data_q[i-1];
          end
        end
      end
    end
  end

  // Occupancy is the popcount of next-state valids, so count tracks valid_q exactly.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CW'(valid_d[i]);
    end
  end

  // Stage registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RST_VAL;
      end
      valid_q <= '0;
      count   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count   <= count_d;
    end
  end

  // Handshakes are blocked while set or clear is active, and in_ready also
  // drops combinationally while reset is held.
  assign in_ready  = rst_n & set_n & ~clr & load_en[0];
  assign out_valid = valid_q[DEPTH-1] & set_n & ~clr;
  assign out_data  = data_q[DEPTH-1];

endmodule
